count_pwm: RTL
==============

// Module: count_pwm
// PURPOSE
//  Downstream consumer of the free-running 3-bit simple_counter output. Compares the
//  incoming count against a programmable duty threshold to produce a registered PWM
//  waveform, one period per counter wrap. Duty updates arrive on a valid/ready
//  handshake and are double-buffered so they apply only at a period boundary (glitch-free).
// PARAMETERS
//  CW        3   width of incoming count; period = 2**CW clocks
//  DUTY_W    4   duty width (CW+1) so that 0..2**CW (0%..100%) is representable
// PORTS
//  clk          in   1       system clock, all logic on rising edge
//  rst          in   1       synchronous reset, active-high
//  count        in   CW      counter value from simple_counter, advances by 1 per clk, wraps to 0
//  duty_in      in   DUTY_W  requested high-time in clocks per period
//  duty_valid   in   1       duty_in valid
//  duty_ready   out  1       pending slot free; transfer when duty_valid & duty_ready
//  pwm_out      out  1       PWM waveform, registered
//  period_start out  1       1-clk pulse on first cycle of each period (registered)
// BEHAVIOUR
//  - Reset (rst=1 at posedge): active_duty=0, pending empty, prev_count=0, state=SYNC,
//    pwm_out=0, period_start=0, duty_ready=0 while rst high; duty_ready=1 first clk after.
//  - Wrap detect: wrap = (count < prev_count) | (state==SYNC & count==0). prev_count <= count.
//  - FSM: SYNC (after reset, pwm_out held 0, waiting for count==0) -> RUN on first count==0.
//    RUN stays RUN; only rst returns to SYNC. Mid-period reset: output drops to 0 next clk,
//    resumes at the next count==0 with the latest handshaken duty (pending cleared by rst).
//  - Pending slot: 2-state EMPTY/FULL. duty_ready = ~rst_q & (pending==EMPTY).
//    Accept (valid&ready): pending_duty <= sat(duty_in), pending -> FULL.
//    On wrap with pending FULL: active_duty <= pending_duty, pending -> EMPTY.
//    Accept and wrap same cycle with pending EMPTY: value goes to pending, applied at the
//    NEXT wrap (never to the period starting now). FULL blocks accept, so no collision.
//  - sat(): duty_in > 2**CW clamps to 2**CW (100%).
//  - pwm_out <= (state==RUN) & ({1'b0,count} < duty_eff), duty_eff = active_duty after any
//    same-cycle wrap update. Latency: count -> pwm_out is 1 clk.
//  - duty 0 -> pwm_out constant 0; duty 2**CW -> constant 1 across wraps, no glitch.
//  - period_start <= wrap & (state==RUN or entering RUN).
// CONFIGURATION
//  COUNT_PWM_WRAPCNT_EN defined: adds output wrap_cnt [7:0], reset 0, increments on every
//    period_start, saturates at 255 (no wrap). Not defined: port and logic absent; all
//    other behaviour identical.
// STRUCTURE
//  Shared package count_pwm_pkg: SYNC/RUN and EMPTY/FULL state encodings, DUTY_MAX = 2**CW,
//  WRAPCNT_MAX = 8'd255. One sub-module natural: count_pwm_dbuf (pending/active duty
//  double-buffer with handshake and saturation); compare/FSM stays in top.
// TESTING
//  1. Reset, no duty written, 20 clks -> pwm_out=0 throughout, period_start every 8 clks.
//  2. Write duty 3 before wrap -> from next period pwm_out=1 for count 0,1,2, 0 for 3..7.
//  3. Write 3, then 6 before wrap (ready=0 until wrap) -> 3 applies, 6 accepted after wrap,
//     applies one period later; no partial period at either value.
//  4. duty_in=8 then 15 -> both give pwm_out=1 continuously; duty 0 -> constant 0.
//  5. Accept on the exact wrap cycle with pending empty -> applied at following wrap only.
//  6. Assert rst at count=4 mid-period with duty 5 -> pwm_out=0 next clk, active_duty=0,
//     stays 0 until a new duty is written; with COUNT_PWM_WRAPCNT_EN, 300 periods -> 255.

Source files
------------

// File: rtl/count_pwm_pkg.sv
// Shared encodings and limits for the count_pwm slice: run/sync states,
// pending-slot states, default widths and saturation ceilings.
package count_pwm_pkg;

  localparam int unsigned CW_DEFAULT = 3;
  localparam logic [CW_DEFAULT:0] DUTY_MAX = 4'd8;
  localparam logic [7:0] WRAPCNT_MAX = 8'd255;

  typedef enum logic [0:0] {
    SYNC = 1'b0,
    RUN  = 1'b1
  } run_state_e;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/count_pwm_dbuf.sv
// Duty double-buffer: a one-deep pending slot filled over valid/ready, promoted
// to the active duty only on a period wrap so a period never mixes two duties.
module count_pwm_dbuf
  import count_pwm_pkg::*;
#(
  parameter int unsigned CW     = CW_DEFAULT,
  parameter int unsigned DUTY_W = CW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DUTY_W-1:0] duty_in,
  input  logic              duty_valid,
  output logic              duty_ready,
  input  logic              wrap,
  output logic [DUTY_W-1:0] duty_eff
);

  localparam logic [DUTY_W-1:0] DMAX = DUTY_W'(1 << CW);

  function automatic logic [DUTY_W-1:0] sat_duty(input logic [DUTY_W-1:0] d);
    if (d > DMAX) begin
      return DMAX;
    end else begin
      return d;
    end
  endfunction

  logic              rst_q_r;
  slot_state_e       pend_r;
  logic [DUTY_W-1:0] pend_duty_r;
  logic [DUTY_W-1:0] active_duty_r;
  logic              accept_s;
  logic              load_s;

  // Accept needs an empty slot and load needs a full one, so both never coincide.
  assign duty_ready = ~rst_q_r & (pend_r == EMPTY);
  assign accept_s   = duty_valid & duty_ready;
  assign load_s     = wrap & (pend_r == FULL);
  assign duty_eff   = load_s ? pend_duty_r : active_duty_r;

  // Pending slot, active duty and reset-follower register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rst_q_r       <= 1'b1;
      pend_r        <= EMPTY;
      pend_duty_r   <= {DUTY_W{1'b0}};
      active_duty_r <= {DUTY_W{1'b0}};
    end else begin
      rst_q_r <= 1'b0;
      if (accept_s) begin
        pend_r      <= FULL;
        pend_duty_r <= sat_duty(duty_in);
      end else if (load_s) begin
        pend_r        <= EMPTY;
        active_duty_r <= pend_duty_r;
      end else begin
        pend_r <= pend_r;
      end
    end
  end

endmodule

// File: rtl/count_pwm.sv
// PWM generator driven by an external free-running counter; duty updates are
// double-buffered to period boundaries. Optional COUNT_PWM_WRAPCNT_EN adds a
// saturating period counter output wrap_cnt.
module count_pwm
  import count_pwm_pkg::*;
#(
  parameter int unsigned CW     = CW_DEFAULT,
  parameter int unsigned DUTY_W = CW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CW-1:0]     count,
  input  logic [DUTY_W-1:0] duty_in,
  input  logic              duty_valid,
  output logic              duty_ready,
  output logic              pwm_out,
  output logic              period_start
`ifdef COUNT_PWM_WRAPCNT_EN
  ,
  output logic [7:0]        wrap_cnt
`endif
);

  run_state_e        state_r;
  run_state_e        state_nxt_s;
  logic [CW-1:0]     prev_count_r;
  logic              wrap_s;
  logic              enter_run_s;
  logic              run_s;
  logic              ps_nxt_s;
  logic [DUTY_W-1:0] duty_eff_s;
  logic              pwm_r;
  logic              ps_r;

  count_pwm_dbuf #(
    .CW     (CW),
    .DUTY_W (DUTY_W)
  ) u_dbuf (
    .clk        (clk),
    .rst        (rst),
    .duty_in    (duty_in),
    .duty_valid (duty_valid),
    .duty_ready (duty_ready),
    .wrap       (wrap_s),
    .duty_eff   (duty_eff_s)
  );

  // Next state: leave SYNC on the first zero count; only reset returns to SYNC.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      SYNC: begin
        if (count == {CW{1'b0}}) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = SYNC;
        end
      end
      RUN:     state_nxt_s = RUN;
      default: state_nxt_s = SYNC;
    endcase
  end

  // Wrap and run qualifiers; the entering cycle already counts as running so the
  // first period after sync is complete rather than missing its count-0 slot.
  always_comb begin
    wrap_s      = (count < prev_count_r) |
                  ((state_r == SYNC) & (count == {CW{1'b0}}));
    enter_run_s = (state_r == SYNC) & (state_nxt_s == RUN);
    run_s       = (state_r == RUN) | enter_run_s;
    ps_nxt_s    = wrap_s & run_s;
  end

  // State, previous count and registered waveform outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= SYNC;
      prev_count_r <= {CW{1'b0}};
      pwm_r        <= 1'b0;
      ps_r         <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      prev_count_r <= count;
      pwm_r        <= run_s & ({1'b0, count} < duty_eff_s);
      ps_r         <= ps_nxt_s;
    end
  end

  assign pwm_out      = pwm_r;
  assign period_start = ps_r;

`ifdef COUNT_PWM_WRAPCNT_EN
  logic [7:0] wrap_cnt_r;

  // Saturating count of period starts, aligned with the period_start pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_cnt_r <= 8'd0;
    end else if (ps_nxt_s && (wrap_cnt_r != WRAPCNT_MAX)) begin
      wrap_cnt_r <= wrap_cnt_r + 8'd1;
    end else begin
      wrap_cnt_r <= wrap_cnt_r;
    end
  end

  assign wrap_cnt = wrap_cnt_r;
`endif

endmodule
